// File: rtl/call_return_stack_pkg.sv
// call_return_stack_pkg: shared program-flow types and {call,ret} op encodings
package call_return_stack_pkg;
  localparam int ADDR_W_DEF = 20;
  typedef logic [ADDR_W_DEF-1:0] addr_t;
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RET  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_TAIL = 2'b11;
endpackage

// File: rtl/call_return_stack_lifo.sv
// ret_addr_lifo: return-address storage array, indexed write, combinational indexed read
module ret_addr_lifo #(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [ADDR_W-1:0] rdata
);
  logic [ADDR_W-1:0] mem [DEPTH];
  // data entries carry no reset; only the depth register decides validity
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/call_return_stack.sv
// call_return_stack: CALL/RET return-address stack driving a registered next-PC
module call_return_stack
  import call_return_stack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] call_address,
  input  logic              err_clear,
  output logic [ADDR_W-1:0] new_pc,
  output logic              taken,
  output logic [PTR_W:0]    depth,
  output logic              empty,
  output logic              full,
  output logic              overflow_err,
  output logic              underflow_err
);
  localparam logic [PTR_W:0] FULL_D = DEPTH[PTR_W:0];
  logic [1:0] op;
  logic [ADDR_W-1:0] pc_inc, rdata, new_pc_d;
  logic [PTR_W:0] top_idx, depth_d;
  logic push, tail, pop, ovf, unf, we;
  logic [PTR_W-1:0] waddr;
  assign op      = {call, ret};
  assign pc_inc  = pc + 1'b1;
  assign empty   = depth == '0;
  assign full    = depth == FULL_D;
  assign top_idx = depth - 1'b1;
  // decode the op against stack occupancy; an empty tail call degrades to a plain push
  always_comb begin
    push     = (op == OP_CALL && !full) || (op == OP_TAIL && empty);
    tail     = op == OP_TAIL && !empty;
    pop      = op == OP_RET && !empty;
    ovf      = op == OP_CALL && full;
    unf      = op == OP_RET && empty;
    we       = push || tail;
    waddr    = tail ? top_idx[PTR_W-1:0] : depth[PTR_W-1:0];
    depth_d  = push ? depth + 1'b1 : pop ? top_idx : depth;
    new_pc_d = we ? call_address : pop ? rdata : pc_inc;
  end
  ret_addr_lifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_lifo (
    .clk  (clk),
    .we   (we && !rst),
    .waddr(waddr),
    .wdata(pc_inc),
    .raddr(top_idx[PTR_W-1:0]),
    .rdata(rdata)
  );
  // register next-PC, occupancy and sticky errors; a new error beats err_clear
  always_ff @(posedge clk) begin
    if (rst) begin
      new_pc        <= '0;
      taken         <= 1'b0;
      depth         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      new_pc        <= new_pc_d;
      taken         <= we || pop;
      depth         <= depth_d;
      overflow_err  <= ovf || (overflow_err && !err_clear);
      underflow_err <= unf || (underflow_err && !err_clear);
    end
  end
endmodule

// File: tb/tb_call_return_stack.sv
// tb_call_return_stack: directed and randomized checks against a queue-based stack model
module tb_call_return_stack;
  import call_return_stack_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b0, call = 1'b0, ret = 1'b0, err_clear = 1'b0;
  addr_t pc = '0, call_address = '0, new_pc;
  logic [3:0] depth;
  logic taken, empty, full, overflow_err, underflow_err;
  int tests = 0, failed = 0;
  addr_t stk[$];
  addr_t m_new = '0;
  logic m_taken = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  call_return_stack #(.ADDR_W(20), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .call(call), .ret(ret),
    .call_address(call_address), .err_clear(err_clear), .new_pc(new_pc),
    .taken(taken), .depth(depth), .empty(empty), .full(full),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input logic with_call);
    rst = 1'b1; call = with_call; ret = 1'b0; pc = 20'h00333; call_address = 20'h44444;
    @(posedge clk); #1;
    rst = 1'b0; call = 1'b0;
    stk.delete(); m_new = '0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic step(input logic c, input logic r, input addr_t a, input addr_t p, input logic ec);
    addr_t pc1;
    call = c; ret = r; call_address = a; pc = p; err_clear = ec;
    pc1 = p + 20'h1;
    if (ec) begin m_ovf = 1'b0; m_unf = 1'b0; end
    m_new = pc1; m_taken = 1'b0;
    if (c && (!r || stk.size() == 0)) begin
      if (stk.size() < DEPTH) begin stk.push_back(pc1); m_new = a; m_taken = 1'b1; end
      else m_ovf = 1'b1;
    end else if (c && r) begin
      stk[stk.size()-1] = pc1; m_new = a; m_taken = 1'b1;
    end else if (r) begin
      if (stk.size() > 0) begin m_new = stk.pop_back(); m_taken = 1'b1; end
      else m_unf = 1'b1;
    end
    @(posedge clk); #1;
    call = 1'b0; ret = 1'b0; err_clear = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    tests++; if (new_pc !== 20'h0 || taken !== 1'b0 || depth !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      failed++; $display("FAIL reset_state got pc=%h t=%b d=%0d e=%b f=%b o=%b u=%b", new_pc, taken, depth, empty, full, overflow_err, underflow_err); end
    step(1'b0, 1'b0, 20'h0, 20'h00010, 1'b0);
    tests++; if (new_pc !== 20'h00011 || taken !== 1'b0 || depth !== 4'd0 || empty !== 1'b1) begin
      failed++; $display("FAIL idle got pc=%h t=%b d=%0d e=%b exp pc=00011 t=0 d=0 e=1", new_pc, taken, depth, empty); end
  endtask

  task automatic test_call_ret;
    step(1'b1, 1'b0, 20'hABCDE, 20'h00100, 1'b0);
    tests++; if (new_pc !== 20'hABCDE || taken !== 1'b1 || depth !== 4'd1) begin
      failed++; $display("FAIL call got pc=%h t=%b d=%0d exp pc=abcde t=1 d=1", new_pc, taken, depth); end
    step(1'b0, 1'b1, 20'h0, 20'hABCDE, 1'b0);
    tests++; if (new_pc !== 20'h00101 || taken !== 1'b1 || depth !== 4'd0) begin
      failed++; $display("FAIL ret got pc=%h t=%b d=%0d exp pc=00101 t=1 d=0", new_pc, taken, depth); end
  endtask

  task automatic test_nested_overflow;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 20'h10000 + addr_t'(i), addr_t'(i), 1'b0);
    tests++; if (depth !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
      failed++; $display("FAIL nested_full got d=%0d f=%b e=%b exp d=8 f=1 e=0", depth, full, empty); end
    step(1'b1, 1'b0, 20'h12345, 20'h00008, 1'b0);
    tests++; if (overflow_err !== 1'b1 || taken !== 1'b0 || new_pc !== 20'h00009 || depth !== 4'd8) begin
      failed++; $display("FAIL overflow got o=%b t=%b pc=%h d=%0d exp o=1 t=0 pc=00009 d=8", overflow_err, taken, new_pc, depth); end
    for (int i = 8; i >= 1; i--) begin
      step(1'b0, 1'b1, 20'h0, 20'h77777, 1'b0);
      tests++; if (new_pc !== addr_t'(i) || taken !== 1'b1 || depth !== 4'(i - 1)) begin
        failed++; $display("FAIL lifo_pop%0d got pc=%h t=%b d=%0d exp pc=%h t=1 d=%0d", i, new_pc, taken, depth, addr_t'(i), i - 1); end
    end
  endtask

  task automatic test_underflow_clear;
    do_reset(1'b0);
    step(1'b0, 1'b1, 20'h0, 20'h00050, 1'b0);
    tests++; if (underflow_err !== 1'b1 || taken !== 1'b0 || depth !== 4'd0 || new_pc !== 20'h00051) begin
      failed++; $display("FAIL underflow got u=%b t=%b d=%0d pc=%h exp u=1 t=0 d=0 pc=00051", underflow_err, taken, depth, new_pc); end
    step(1'b0, 1'b0, 20'h0, 20'h00052, 1'b1);
    tests++; if (underflow_err !== 1'b0) begin
      failed++; $display("FAIL err_clear got u=%b exp 0", underflow_err); end
    step(1'b0, 1'b1, 20'h0, 20'h00053, 1'b1);
    tests++; if (underflow_err !== 1'b1) begin
      failed++; $display("FAIL clear_vs_set got u=%b exp 1", underflow_err); end
  endtask

  task automatic test_wrap;
    step(1'b1, 1'b0, 20'h0ABCD, 20'hFFFFF, 1'b0);
    step(1'b0, 1'b1, 20'h0, 20'h0ABCD, 1'b0);
    tests++; if (new_pc !== 20'h00000 || taken !== 1'b1) begin
      failed++; $display("FAIL wrap got pc=%h t=%b exp pc=00000 t=1", new_pc, taken); end
  endtask

  task automatic test_tail_and_reset;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 20'h20000, 20'h00100 + addr_t'(i), 1'b0);
    step(1'b1, 1'b1, 20'h55555, 20'h00200, 1'b0);
    tests++; if (depth !== 4'd3 || new_pc !== 20'h55555 || taken !== 1'b1) begin
      failed++; $display("FAIL tail_call got d=%0d pc=%h t=%b exp d=3 pc=55555 t=1", depth, new_pc, taken); end
    step(1'b0, 1'b1, 20'h0, 20'h55555, 1'b0);
    tests++; if (new_pc !== 20'h00201 || depth !== 4'd2) begin
      failed++; $display("FAIL tail_ret got pc=%h d=%0d exp pc=00201 d=2", new_pc, depth); end
    step(1'b1, 1'b0, 20'h20000, 20'h00300, 1'b0);
    do_reset(1'b1);
    tests++; if (depth !== 4'd0 || empty !== 1'b1 || new_pc !== 20'h0 || taken !== 1'b0) begin
      failed++; $display("FAIL mid_reset got d=%0d e=%b pc=%h t=%b exp d=0 e=1 pc=00000 t=0", depth, empty, new_pc, taken); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset($urandom_range(0, 1) == 1);
      else step($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 4, addr_t'($urandom),
                ($urandom_range(0, 7) == 0) ? 20'hFFFFF : addr_t'($urandom), $urandom_range(0, 15) == 0);
      tests++; if (new_pc !== m_new || taken !== m_taken || depth !== 4'(stk.size()) ||
                   empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH) ||
                   overflow_err !== m_ovf || underflow_err !== m_unf) begin
        failed++; $display("FAIL random%0d got pc=%h t=%b d=%0d e=%b f=%b o=%b u=%b exp pc=%h t=%b d=%0d o=%b u=%b",
          n, new_pc, taken, depth, empty, full, overflow_err, underflow_err, m_new, m_taken, stk.size(), m_ovf, m_unf); end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_call_ret;
    test_nested_overflow;
    test_underflow_clear;
    test_wrap;
    test_tail_and_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/call_return_stack.md
Name: call_return_stack

Overview:
- Return side of program flow, complementing the conditional-jump unit.
- On CALL, pushes the return address (pc+1) onto a hardware LIFO and redirects to the call target.
- On RET, pops the LIFO and redirects to the saved address.
- Sits beside the jump units and feeds the PC register through a registered next-PC output.

Parameters:
ADDR_W, 20, program-counter / address width
DEPTH, 8, number of return-address entries; power of two, at least 2
PTR_W, $clog2(DEPTH), stack pointer width (derived, not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
pc  input  ADDR_W  current program counter
call  input  1  execute CALL this cycle
ret  input  1  execute RET this cycle
call_address  input  ADDR_W  CALL target
err_clear  input  1  clears sticky error flags
new_pc  output  ADDR_W  registered next program counter
taken  output  1  registered; 1 when new_pc is a redirect (call target or popped address)
depth  output  PTR_W+1  number of valid entries, 0..DEPTH
empty  output  1  depth==0 (combinational from depth register)
full  output  1  depth==DEPTH (combinational from depth register)
overflow_err  output  1  sticky; CALL attempted while full
underflow_err  output  1  sticky; RET attempted while empty

Behaviour:
- Reset, synchronous on rst=1 at a clock edge:
  - new_pc=0, taken=0, depth=0, empty=1, full=0, overflow_err=0, underflow_err=0.
  - Entry contents undefined, never read.
  - Reset mid-operation discards all entries and any request in that cycle.
- Latency: one cycle. Request sampled at edge N; new_pc/taken/depth valid after edge N.
- Return address = pc+1, modulo 2^ADDR_W: pc=20'hFFFFF gives 20'h00000.
- Per cycle, by {call,ret}:
  - 00 (idle): new_pc<=pc+1, taken<=0, stack unchanged.
  - 10, not full: mem[depth]<=pc+1, depth+1, new_pc<=call_address, taken<=1.
  - 10, full: no push, overflow_err<=1, new_pc<=pc+1, taken<=0.
  - 01, not empty: new_pc<=mem[depth-1], depth-1, taken<=1.
  - 01, empty: no pop, underflow_err<=1, new_pc<=pc+1, taken<=0.
  - 11 (tail call), not empty: top entry overwritten with pc+1, depth unchanged, new_pc<=call_address, taken<=1.
  - 11, empty: behaves as a push (same as 10 not-full).
- Same-cycle push-then-pop across consecutive cycles: the pop returns the just-pushed value; no bypass hazard, since the write lands before the next read.
- Error flags:
  - Set only by the conditions above; cleared by rst or err_clear.
  - If err_clear and a new error occur in the same cycle, set wins.
- depth never exceeds DEPTH and never underflows; full and empty are never both 1.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package (program-flow package):
  - ADDR_W default constant.
  - Typedef for addr_t.
  - Localparam encodings for the {call,ret} op cases, reused by the jump and PC units.
- One sub-module: ret_addr_lifo.
  - DEPTH x ADDR_W register array with write-at-index and read-at-index.
  - No reset on data.
- Top owns pointer/depth, error flags and next-PC mux.

Test Plan:
- Reset then idle with pc=20'h00010 -> new_pc=20'h00011, taken=0, depth=0, empty=1.
- CALL pc=20'h00100, call_address=20'hABCDE, then RET next cycle -> after edge 1: new_pc=20'hABCDE, taken=1, depth=1; after edge 2: new_pc=20'h00101, taken=1, depth=0.
- Eight nested CALLs with pc=20'h00000..20'h00007, then a ninth CALL -> depth=8, full=1; ninth: overflow_err=1, taken=0, new_pc=pc+1. Eight RETs then return 20'h00008..20'h00001 in LIFO order.
- RET on empty stack -> underflow_err=1, taken=0, depth=0. err_clear pulse -> flag returns to 0. err_clear with a simultaneous empty RET -> flag stays 1.
- CALL at pc=20'hFFFFF, then RET -> popped new_pc=20'h00000 (wrap).
- Tail call {call,ret}=11 with depth=3 and pc=20'h00200 -> depth stays 3, new_pc=call_address, and the next RET returns 20'h00201. rst asserted mid-sequence with depth=3 -> depth=0, empty=1, new_pc=0.
